// File: rtl/salsa_core_arbiter.sv
// Round-robin scheduler sharing one Salsa20/8 core among N_REQ lanes.
// Ports: req_* lane side, rsp_* result side, core_* to the shared core,
// busy/timeout_err status.
module salsa_core_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [512*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [511:0]           rsp_data,
  output logic                   core_init,
  output logic [511:0]           core_x,
  input  logic [511:0]           core_out,
  input  logic                   core_valid,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] LSB1 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e              state_q;
  logic [PW-1:0]       rr_q;
  logic [PW-1:0]       owner_q;
  logic [511:0]        in_q;
  logic [511:0]        rsp_q;
  logic [CW-1:0]       wd_q;
  logic                init_q;
  logic [N_REQ-1:0]    rspv_q;
  logic                busy_q;
  logic                terr_q;

  logic                gnt_any;
  logic [PW-1:0]       gnt_idx;
  logic [511:0]        gnt_data;

  // Scan downward over offsets from rr_q so the last hit written is
  // the lowest offset, i.e. the first requester at or after rr_q.
  always_comb begin
    int k;
    k        = 0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(rr_q) + i) % N_REQ;
      if (req_valid[k]) begin
        gnt_any  = 1'b1;
        gnt_idx  = PW'(k);
        gnt_data = req_data[512*k +: 512];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_any) begin
      req_ready = LSB1 << gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      in_q    <= '0;
      rsp_q   <= '0;
      wd_q    <= '0;
      init_q  <= 1'b0;
      rspv_q  <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      init_q <= 1'b0;
      rspv_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            in_q    <= gnt_data;
            owner_q <= gnt_idx;
            rr_q    <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
            init_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Completion has priority over the watchdog expiring.
          if (core_valid) begin
            rsp_q   <= core_out;
            rspv_q  <= LSB1 << owner_q;
            state_q <= DONE;
          end else if (wd_q == WD_MAX) begin
            terr_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + CW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = rspv_q;
  assign rsp_data    = rsp_q;
  assign core_init   = init_q;
  assign core_x      = in_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_salsa_core_arbiter.sv
// Randomized and directed bench for salsa_core_arbiter with a stub core
// (result word = input word + 1 after a programmable latency).
module tb_salsa_core_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     lane_v;
  logic [511:0]     lane_d [N];
  logic [512*N-1:0] req_data;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [511:0]     rsp_data;
  logic             core_init;
  logic [511:0]     core_x;
  logic [511:0]     core_out;
  logic             core_valid;
  logic             busy;
  logic             timeout_err;

  salsa_core_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(lane_v),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .core_init(core_init),
    .core_x(core_x),
    .core_out(core_out),
    .core_valid(core_valid),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[512*i +: 512] = lane_d[i];
  end

  function automatic logic [511:0] add1(input logic [511:0] b);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = b[32*k +: 32] + 32'd1;
    return r;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  // stub core
  int           cyc = 0;
  int           due = 0;
  int           lat = 8;
  bit           pend = 0;
  bit           stub_en = 1;
  bit           stray = 0;
  logic [511:0] x_cap = '0;
  logic         stub_v;

  assign stub_v     = pend && (cyc == due);
  assign core_valid = stub_v | stray;
  assign core_out   = add1(x_cap);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (stub_v) pend <= 1'b0;
      if (core_init && stub_en) begin
        pend  <= 1'b1;
        due   <= cyc + lat;
        x_cap <= core_x;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: a job occupies a fixed number of busy cycles
  int           m_left = 0;
  int           m_total = 0;
  int           m_owner = 0;
  int           m_ptr = 0;
  bit           m_to = 0;
  bit           m_terr = 0;
  logic [511:0] m_x = '0;
  logic [511:0] m_rsp = '0;

  int           acc_q[$];
  int           rsp_cnt = 0;
  int           last_lane = -1;
  logic [511:0] last_data = '0;
  bit           gen_en = 0;

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      if (lane_v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic step();
    int         g;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    logic [N-1:0] acc;
    @(negedge clk);
    g  = -1;
    er = '0;
    ev = '0;
    if (m_left == 0) g = pick();
    if (g >= 0) er[g] = 1'b1;
    if (m_left == 1 && !m_to) ev[m_owner] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_left != 0);
    chk("core_init", core_init, m_left != 0 && m_left == m_total);
    chk("rsp_valid", rsp_valid, ev);
    chk("core_x", core_x, m_x);
    chk("rsp_data", rsp_data, m_rsp);
    chk("timeout_err", timeout_err, m_terr);
    acc = req_ready & lane_v;
    for (int i = 0; i < N; i++) if (acc[i]) acc_q.push_back(i);
    if (|rsp_valid) begin
      rsp_cnt++;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) last_lane = i;
      last_data = rsp_data;
    end
    if (reset) begin
      m_left  = 0;
      m_ptr   = 0;
      m_owner = 0;
      m_x     = '0;
      m_rsp   = '0;
      m_terr  = 0;
    end else if (m_left == 0) begin
      if (g >= 0) begin
        m_x     = lane_d[g];
        m_owner = g;
        m_ptr   = (g + 1) % N;
        m_to    = !stub_en || (lat > TO + 1);
        m_total = m_to ? TO + 2 : lat + 2;
        m_left  = m_total;
      end
    end else begin
      if (m_left == 2 && !m_to) m_rsp = add1(m_x);
      if (m_left == 1 && m_to) m_terr = 1;
      m_left--;
    end
    @(posedge clk);
    #1;
    lane_v = lane_v & ~acc;
    if (gen_en) begin
      for (int i = 0; i < N; i++) begin
        if (!lane_v[i] && $urandom_range(3) == 0) begin
          lane_v[i] = 1'b1;
          lane_d[i] = rand_blk();
        end
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((m_left != 0 || lane_v != '0) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_bound", n < maxc, 1'b1);
  endtask

  int c0;

  initial begin
    reset  = 1'b1;
    lane_v = '0;
    for (int i = 0; i < N; i++) lane_d[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    step();

    // all four lanes at once, then lane 1 alone
    lat = 8;
    for (int i = 0; i < N; i++) begin
      lane_v[i] = 1'b1;
      lane_d[i] = rand_blk();
    end
    drain(300);
    lane_v[1] = 1'b1;
    lane_d[1] = rand_blk();
    drain(100);
    chk("rr4_n", acc_q.size(), 5);
    chk("rr4_g0", acc_q[0], 0);
    chk("rr4_g1", acc_q[1], 1);
    chk("rr4_g2", acc_q[2], 2);
    chk("rr4_g3", acc_q[3], 3);
    chk("rr4_g4", acc_q[4], 1);
    chk("rr4_lane", last_lane, 1);

    // single job on lane 2 with counting words
    for (int k = 0; k < 16; k++) lane_d[2][32*k +: 32] = k;
    lane_v[2] = 1'b1;
    drain(100);
    chk("one_lane", last_lane, 2);
    chk("one_w0", last_data[31:0], 32'h1);
    chk("one_w15", last_data[511:480], 32'h10);

    // wrap: lanes 3 and 0 with pointer at 3
    acc_q.delete();
    lane_v[3] = 1'b1;
    lane_d[3] = rand_blk();
    lane_v[0] = 1'b1;
    lane_d[0] = rand_blk();
    drain(100);
    chk("wrap_n", acc_q.size(), 2);
    chk("wrap_g0", acc_q[0], 3);
    chk("wrap_g1", acc_q[1], 0);

    // silent core trips the watchdog
    c0 = rsp_cnt;
    stub_en = 0;
    lane_v[1] = 1'b1;
    lane_d[1] = rand_blk();
    drain(100);
    chk("to_err", timeout_err, 1'b1);
    chk("to_norsp", rsp_cnt - c0, 0);
    stub_en = 1;
    lane_v[2] = 1'b1;
    lane_d[2] = rand_blk();
    drain(100);
    chk("to_sticky", timeout_err, 1'b1);
    chk("to_next", rsp_cnt - c0, 1);

    // completion in the last watchdog cycle wins; one later loses
    lat = TO + 1;
    lane_v[0] = 1'b1;
    lane_d[0] = rand_blk();
    drain(100);
    chk("edge_win", rsp_cnt - c0, 2);
    lat = TO + 2;
    lane_v[3] = 1'b1;
    lane_d[3] = rand_blk();
    drain(100);
    repeat (3) step();
    chk("edge_lose", rsp_cnt - c0, 2);

    // reset in the fourth WAIT cycle
    lat = 8;
    lane_v[3] = 1'b1;
    lane_d[3] = rand_blk();
    step();
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    c0 = rsp_cnt;
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    stray = 1'b1;
    step();
    stray = 1'b0;
    repeat (12) step();
    chk("rst_norsp", rsp_cnt - c0, 0);

    // stray completion while idle
    c0 = rsp_cnt;
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    chk("idle_stray", rsp_cnt - c0, 0);

    // random traffic at several latencies
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(1, 7);
      gen_en = 1;
      repeat (150) step();
      gen_en = 0;
      drain(400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/salsa_core_arbiter.md
# salsa_core_arbiter

Round-robin scheduler that shares one `salsa_20_8` core between `N_REQ` ROMix lanes. It accepts one 512-bit block from a requesting lane and holds that block on the core inputs. It pulses the core's `init`, waits for the core's `valid`, and returns the 512-bit result to the lane that issued the job. A watchdog flags a core that never answers. The block sits between the ROMix lane array and the single shared Salsa20/8 instance.

## Interface
- `N_REQ`, default 4: number of requesting lanes (2..8).
- `TIMEOUT`, default 255: maximum cycles in WAIT before abort; counter width is `$clog2(TIMEOUT+1)`.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: lane i holds a job; held high until `req_ready[i]`.
- `req_data` input 512*N_REQ: lane i block at `[512*i +: 512]`; word k at `[32*k +: 32]`.
- `req_ready` output N_REQ: one-hot accept strobe, combinational.
- `rsp_valid` output N_REQ: one-hot, one-cycle result strobe to the owning lane.
- `rsp_data` output 512: result block, shared by all lanes; word k = core `out_k`.
- `core_init` output 1: init pulse to the core.
- `core_x` output 512: word k drives core `x_k`.
- `core_out` input 512: word k from core `out_k`.
- `core_valid` input 1: core completion pulse.
- `busy` output 1: high in any state other than IDLE.
- `timeout_err` output 1: sticky flag; cleared only by `reset`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `req_valid` is set, grant g = the first set bit at or after `rr_ptr`, scanning upward with wrap.
  - Assert `req_ready[g]` in that cycle.
  - On the clock edge: `in_reg <= req_data[g]`, `owner <= g`, `rr_ptr <= (g+1) mod N_REQ`, state goes to ISSUE.
  - If no `req_valid` is set, stay in IDLE with `req_ready` = 0.
- ISSUE: `core_init` = 1 for exactly one cycle; clear `wd_cnt`; go to WAIT.
- WAIT:
  - On `core_valid`: `rsp_reg <= core_out`, go to DONE.
  - Otherwise, once `wd_cnt` reaches `TIMEOUT`: set `timeout_err`, discard the job, return to IDLE with no `rsp_valid`.
  - Otherwise increment `wd_cnt`.
- DONE: `rsp_valid[owner]` = 1 for one cycle, `rsp_data` = `rsp_reg`; go to IDLE.
- `core_x` = `in_reg` at all times. It stays stable from ISSUE through WAIT and changes only on an IDLE grant.
- `rsp_data` holds the last result until the next DONE capture.
- Boundary conditions:
  - `core_valid` in IDLE, ISSUE or DONE is ignored.
  - `core_valid` in the same cycle as `wd_cnt == TIMEOUT`: completion wins and there is no error.
  - `req_ready` is never asserted outside IDLE. Lanes keep `req_valid` high through non-IDLE states with no loss.
  - Only one job is ever outstanding.
  - `rr_ptr` wraps from `N_REQ-1` to 0.
- Reset mid-operation: the FSM returns to IDLE and the in-flight job is dropped with no `rsp_valid`. The core is reset by the same top-level reset (`reset_n = ~reset`).
- Reset values:
  - State IDLE, `rr_ptr` 0, `owner` 0.
  - `in_reg`, `rsp_reg` and `wd_cnt` 0.
  - `req_ready`, `rsp_valid`, `core_init`, `busy` and `timeout_err` 0.

## Timing
- Accept in cycle T (IDLE, `req_ready` high).
- `core_init` high in T+1.
- The core raises `core_valid` L cycles after sampling `init`, i.e. in cycle T+1+L.
- `rsp_valid` in T+2+L.
- IDLE in T+3+L. A new grant is possible in that same cycle, so throughput is one job per L+3 cycles.
- `busy` high from T+1 through T+2+L.
- Timeout: error set at the edge ending the WAIT cycle where `wd_cnt == TIMEOUT`; IDLE follows TIMEOUT+2 cycles after ISSUE.

## Test plan
- Single job, stub core with L=8 returning word k = x_k + 1. Lane 2 sends words 0x00000000..0x0000000F. Required: `req_ready[2]` in cycle T, `core_init` at T+1, `rsp_valid` = 4'b0100 at T+10, words 0x00000001..0x00000010.
- All four lanes request at once from reset. Required: grants in order 0,1,2,3, each response routed to the correct lane, each result matching its own input+1. Then lane 1 alone is served next, with `rr_ptr` = 0 before that grant.
- Lanes 3 and 0 request while `rr_ptr` = 3. Required: lane 3 is granted first, then lane 0 (wrap).
- Stub core never responds, `TIMEOUT` = 15. Required: `timeout_err` = 1, no `rsp_valid`, return to IDLE. The next job completes normally and `timeout_err` stays 1.
- `reset` pulsed in the fourth WAIT cycle. Required: all outputs 0 the next cycle, no `rsp_valid`; a stray `core_valid` after reset has no effect.
- `core_valid` pulsed while in IDLE with no requests. Required: no `rsp_valid`, `rsp_data` unchanged.
